// File: rtl/time_uart_tx.sv
// Serial time-report transmitter: snapshots hour/min/sec/centiseconds on request and
// sends "HH:MM:SS.CC\r\n" as back-to-back 8N1 frames, LSB first.
module time_uart_tx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req,
  input  logic [6:0] msec,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int TMR_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(BIT_CYC - 1);
  localparam logic [3:0]       LAST_CHAR = 4'd12;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic [3:0]       char_idx;
  logic [2:0]       bit_idx;
  logic [7:0]       bcd_hour, bcd_min, bcd_sec, bcd_msec;
  logic [7:0]       cur_char;

  // Fields are converted to two BCD digits at capture time; anything above 99 reads as 99.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [6:0] s;
    logic [3:0] tens;
    logic [3:0] ones;
    s    = (v > 7'd99) ? 7'd99 : v;
    tens = 4'(s / 7'd10);
    ones = 4'(s % 7'd10);
    return {tens, ones};
  endfunction

  always_comb begin
    cur_char = 8'h0A;
    case (char_idx)
      4'd0:    cur_char = {4'h3, bcd_hour[7:4]};
      4'd1:    cur_char = {4'h3, bcd_hour[3:0]};
      4'd2:    cur_char = 8'h3A;
      4'd3:    cur_char = {4'h3, bcd_min[7:4]};
      4'd4:    cur_char = {4'h3, bcd_min[3:0]};
      4'd5:    cur_char = 8'h3A;
      4'd6:    cur_char = {4'h3, bcd_sec[7:4]};
      4'd7:    cur_char = {4'h3, bcd_sec[3:0]};
      4'd8:    cur_char = 8'h2E;
      4'd9:    cur_char = {4'h3, bcd_msec[7:4]};
      4'd10:   cur_char = {4'h3, bcd_msec[3:0]};
      4'd11:   cur_char = 8'h0D;
      default: cur_char = 8'h0A;
    endcase
  end

  // tmr is a down-counter reloaded with BIT_CYC-1; reaching zero ends the current bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tmr      <= '0;
      char_idx <= '0;
      bit_idx  <= '0;
      bcd_hour <= '0;
      bcd_min  <= '0;
      bcd_sec  <= '0;
      bcd_msec <= '0;
      o_tx     <= 1'b1;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req) begin
            bcd_hour <= to_bcd({2'b00, hour});
            bcd_min  <= to_bcd({1'b0, min});
            bcd_sec  <= to_bcd({1'b0, sec});
            bcd_msec <= to_bcd(msec);
            char_idx <= '0;
            bit_idx  <= '0;
            tmr      <= TMR_LOAD;
            o_tx     <= 1'b0;
            o_busy   <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (tmr == '0) begin
            tmr     <= TMR_LOAD;
            bit_idx <= '0;
            o_tx    <= cur_char[0];
            state   <= DATA;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        DATA: begin
          if (tmr == '0) begin
            tmr <= TMR_LOAD;
            if (bit_idx == 3'd7) begin
              o_tx  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              o_tx    <= cur_char[bit_idx + 3'd1];
            end
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        STOP: begin
          if (tmr == '0) begin
            if (char_idx == LAST_CHAR) begin
              o_busy <= 1'b0;
              o_done <= 1'b1;
              o_tx   <= 1'b1;
              state  <= IDLE;
            end else begin
              // Next frame's start bit follows the stop bit with no idle gap.
              char_idx <= char_idx + 4'd1;
              tmr      <= TMR_LOAD;
              o_tx     <= 1'b0;
              state    <= START;
            end
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_uart_tx.sv
// Bench for time_uart_tx: a line monitor decodes 8N1 frames and checks them against a
// queue of expected characters filled when each request is issued.
module tb_time_uart_tx;

  localparam int CLK_FREQ   = 1000;
  localparam int BAUD       = 100;
  localparam int BIT_CYC    = CLK_FREQ / BAUD;
  localparam int REPORT_CYC = 130 * BIT_CYC;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       i_req = 1'b0;
  logic [6:0] msec  = '0;
  logic [5:0] sec   = '0;
  logic [5:0] min   = '0;
  logic [4:0] hour  = '0;
  logic       o_tx, o_busy, o_done;

  int total = 0;
  int bad   = 0;
  byte unsigned exp_q[$];

  always #5 clk = ~clk;

  time_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst(rst), .i_req(i_req),
    .msec(msec), .sec(sec), .min(min), .hour(hour),
    .o_tx(o_tx), .o_busy(o_busy), .o_done(o_done)
  );

  // Frame decoder: sample point mid-bit, counted from the edge the start bit appeared.
  initial begin : monitor
    int cnt;
    bit active;
    logic [7:0] sh;
    byte unsigned e;
    cnt = 0; active = 0; sh = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        active = 0;
      end else if (!active) begin
        if (o_tx === 1'b0) begin
          active = 1;
          cnt = 0;
        end
      end else begin
        cnt++;
        if (cnt == BIT_CYC / 2) begin
          total++;
          if (o_tx !== 1'b0) begin
            bad++;
            $display("FAIL start_bit: got %b want 0", o_tx);
          end
        end else if (cnt >= BIT_CYC + BIT_CYC / 2 && cnt < 9 * BIT_CYC &&
                     (cnt % BIT_CYC) == BIT_CYC / 2) begin
          sh = {o_tx, sh[7:1]};
        end else if (cnt == 9 * BIT_CYC + BIT_CYC / 2) begin
          total++;
          if (o_tx !== 1'b1) begin
            bad++;
            $display("FAIL stop_bit: got %b want 1", o_tx);
          end
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_frame: got 0x%02h want no frame", sh);
          end else begin
            e = exp_q.pop_front();
            if (sh !== e) begin
              bad++;
              $display("FAIL char: got 0x%02h want 0x%02h", sh, e);
            end
          end
        end
        if (cnt == 10 * BIT_CYC - 1) active = 0;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic set_time(input int h, input int m, input int s, input int ms);
    hour = 5'(h); min = 6'(m); sec = 6'(s); msec = 7'(ms);
  endtask

  task automatic push_line(input int h, input int m, input int s, input int ms);
    int f[4];
    f = '{h, m, s, ms};
    for (int i = 0; i < 4; i++) begin
      int v;
      v = (f[i] > 99) ? 99 : f[i];
      exp_q.push_back(8'(48 + v / 10));
      exp_q.push_back(8'(48 + v % 10));
      if (i < 2) exp_q.push_back(8'h3A);
      else if (i == 2) exp_q.push_back(8'h2E);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Leaves the bench at the sample point just after the accepting edge N.
  task automatic pulse_req();
    @(negedge clk); i_req = 1'b1;
    @(posedge clk); #1; i_req = 1'b0;
    total++;
    if ({o_busy, o_tx, o_done} !== 3'b100) begin
      bad++;
      $display("FAIL accept: got busy/tx/done=%b want 100", {o_busy, o_tx, o_done});
    end
  endtask

  task automatic wait_done(input int k0);
    int k;
    int busy_gaps;
    bit seen;
    busy_gaps = 0; seen = 0;
    for (k = k0 + 1; k <= REPORT_CYC + 50; k++) begin
      @(posedge clk); #1;
      if (o_done === 1'b1) begin
        seen = 1;
        break;
      end
      if (o_busy !== 1'b1) busy_gaps++;
    end
    total++;
    if (!seen || k != REPORT_CYC) begin
      bad++;
      $display("FAIL done_time: got %0d (seen=%0b) want %0d", k, seen, REPORT_CYC);
    end
    total++;
    if (busy_gaps != 0) begin
      bad++;
      $display("FAIL busy_gap: got %0d low cycles want 0", busy_gaps);
    end
    total++;
    if ({o_busy, o_tx} !== 2'b01) begin
      bad++;
      $display("FAIL idle_at_done: got busy/tx=%b want 01", {o_busy, o_tx});
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL frames_pending: got %0d want 0", exp_q.size());
    end
  endtask

  task automatic check_quiet(input int n, input string tag);
    int hits;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if ({o_tx, o_busy, o_done} !== 3'b100) hits++;
    end
    total++;
    if (hits != 0) begin
      bad++;
      $display("FAIL quiet_%s: got %0d active cycles want 0", tag, hits);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({o_tx, o_busy, o_done} !== 3'b100) begin
      bad++;
      $display("FAIL reset_state: got tx/busy/done=%b want 100", {o_tx, o_busy, o_done});
    end
    @(negedge clk); rst = 1'b0;
    check_quiet(20, "after_reset");
    @(posedge clk); #3; rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if ({o_tx, o_busy, o_done} !== 3'b100) begin
      bad++;
      $display("FAIL reset_hold: got tx/busy/done=%b want 100", {o_tx, o_busy, o_done});
    end
    @(negedge clk); rst = 1'b0;
    check_quiet(20, "idle");
  endtask

  task automatic test_full_report();
    set_time(23, 59, 59, 99);
    push_line(23, 59, 59, 99);
    pulse_req();
    wait_done(0);
    check_quiet(20, "after_full");
  endtask

  task automatic test_snapshot();
    set_time(0, 0, 0, 0);
    push_line(0, 0, 0, 0);
    pulse_req();
    repeat (350) begin
      @(posedge clk); #1;
    end
    set_time(12, 34, 56, 78);
    i_req = 1'b1;
    @(posedge clk); #1; i_req = 1'b0;
    wait_done(351);
    check_quiet(200, "no_second_report");
  endtask

  task automatic test_back_to_back();
    set_time(9, 7, 5, 120);
    push_line(9, 7, 5, 120);
    pulse_req();
    wait_done(0);
    push_line(9, 7, 5, 120);
    i_req = 1'b1;
    @(posedge clk); #1; i_req = 1'b0;
    total++;
    if ({o_busy, o_tx, o_done} !== 3'b100) begin
      bad++;
      $display("FAIL b2b_restart: got busy/tx/done=%b want 100", {o_busy, o_tx, o_done});
    end
    wait_done(0);
    check_quiet(10, "after_b2b");
  endtask

  task automatic test_reset_mid();
    set_time(1, 2, 3, 4);
    push_line(1, 2, 3, 4);
    pulse_req();
    repeat (6 * 10 * BIT_CYC + 4 * BIT_CYC) begin
      @(posedge clk); #1;
    end
    #2; rst = 1'b1;
    #1;
    total++;
    if ({o_tx, o_busy, o_done} !== 3'b100) begin
      bad++;
      $display("FAIL async_reset: got tx/busy/done=%b want 100", {o_tx, o_busy, o_done});
    end
    total++;
    if (exp_q.size() != 7) begin
      bad++;
      $display("FAIL chars_before_reset: got %0d pending want 7", exp_q.size());
    end
    exp_q.delete();
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    check_quiet(30, "after_mid_reset");
  endtask

  task automatic test_fresh_after_reset();
    set_time(12, 34, 56, 78);
    push_line(12, 34, 56, 78);
    pulse_req();
    wait_done(0);
  endtask

  initial begin
    test_reset();
    test_full_report();
    test_snapshot();
    test_back_to_back();
    test_reset_mid();
    test_fresh_after_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
